ysyx_22050550_score_board_cnt: RTL and testbench



---
 rtl/ysyx_22050550_score_board_cnt.sv | 111 +++++++++++
 tb/tb_ysyx_22050550_score_board_cnt.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_score_board_cnt.sv
// Register-hazard scoreboard with a pending-write counter per architectural register.
// Optional macro SCORE_BOARD_BYPASS_EN hides busy when the last pending write is retiring this cycle.
module ysyx_22050550_score_board_cnt #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 2,
   parameter int NWB   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_IDU_valid,
   input  logic [AW-1:0]     io_IDU_raddr1,
   input  logic [AW-1:0]     io_IDU_raddr2,
   input  logic [AW-1:0]     io_IDU_waddr,
   input  logic              io_IDU_wen,
   input  logic              io_IDU_fire,
   output logic              io_IDU_busy1,
   output logic              io_IDU_busy2,
   output logic              io_IDU_full,
   input  logic [NWB*AW-1:0] io_WBU_waddr,
   input  logic [NWB-1:0]    io_WBU_wen,
   input  logic              io_flush,
   output logic              io_err
);

   // Wide enough to hold cnt + 1 and a decrement of up to four ports without wrapping.
   localparam int W = CNT_W + 3;
   localparam logic [W-1:0] MAXW = W'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] cnt_q    [NREG];
   logic [CNT_W-1:0] cnt_next [NREG];
   logic             err_q;
   logic             err_next;

   logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_w;
   logic             wb_hit1, wb_hit2;

   always_comb begin
      logic          inc;
      logic [W-1:0]  dec;
      logic [W-1:0]  sum;
      err_next = err_q;
      inc = 1'b0;
      dec = '0;
      sum = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt_next[i] = '0;
         if (i != 0) begin
            inc = io_IDU_fire & io_IDU_wen & (io_IDU_waddr == AW'(i));
            dec = '0;
            for (int k = 0; k < NWB; k++)
               if (io_WBU_wen[k] && io_WBU_waddr[k*AW +: AW] == AW'(i))
                  dec = dec + W'(1);
            sum = W'(cnt_q[i]) + W'(inc);
            // Out-of-balance traffic clamps the counter and raises the sticky error.
            if (dec > sum) begin
               cnt_next[i] = '0;
               err_next    = 1'b1;
            end else if (sum - dec > MAXW) begin
               cnt_next[i] = CNT_W'(MAXW);
               err_next    = 1'b1;
            end else begin
               cnt_next[i] = CNT_W'(sum - dec);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= io_flush ? '0 : cnt_next[i];
         err_q <= err_next;
      end
   end

   // Address decode of counters; x0 and addresses beyond NREG read as zero.
   always_comb begin
      cnt_r1  = '0;
      cnt_r2  = '0;
      cnt_w   = '0;
      wb_hit1 = 1'b0;
      wb_hit2 = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         if (io_IDU_raddr1 == AW'(i)) cnt_r1 = cnt_q[i];
         if (io_IDU_raddr2 == AW'(i)) cnt_r2 = cnt_q[i];
         if (io_IDU_waddr  == AW'(i)) cnt_w  = cnt_q[i];
      end
      for (int k = 0; k < NWB; k++) begin
         if (io_WBU_wen[k] && io_WBU_waddr[k*AW +: AW] == io_IDU_raddr1) wb_hit1 = 1'b1;
         if (io_WBU_wen[k] && io_WBU_waddr[k*AW +: AW] == io_IDU_raddr2) wb_hit2 = 1'b1;
      end
   end

   logic bypass1, bypass2;
`ifdef SCORE_BOARD_BYPASS_EN
   assign bypass1 = wb_hit1 & (cnt_r1 == CNT_W'(1));
   assign bypass2 = wb_hit2 & (cnt_r2 == CNT_W'(1));
`else
   assign bypass1 = 1'b0;
   assign bypass2 = 1'b0;
`endif

   assign io_IDU_busy1 = io_IDU_valid & (cnt_r1 != '0) & ~bypass1;
   assign io_IDU_busy2 = io_IDU_valid & (cnt_r2 != '0) & ~bypass2;
   assign io_IDU_full  = io_IDU_valid & io_IDU_wen & (W'(cnt_w) == MAXW);
   assign io_err       = err_q;

endmodule

// File: tb/tb_ysyx_22050550_score_board_cnt.sv
// Self-checking bench: directed test-plan sequence then random traffic against an integer count model.
module tb_ysyx_22050550_score_board_cnt;
   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 2;
   localparam int NWB   = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic              clock = 1'b0;
   logic              reset;
   logic              io_IDU_valid;
   logic [AW-1:0]     io_IDU_raddr1, io_IDU_raddr2, io_IDU_waddr;
   logic              io_IDU_wen, io_IDU_fire;
   logic              io_IDU_busy1, io_IDU_busy2, io_IDU_full;
   logic [NWB*AW-1:0] io_WBU_waddr;
   logic [NWB-1:0]    io_WBU_wen;
   logic              io_flush;
   logic              io_err;

   ysyx_22050550_score_board_cnt #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W), .NWB(NWB)) dut (
      .clock(clock), .reset(reset),
      .io_IDU_valid(io_IDU_valid), .io_IDU_raddr1(io_IDU_raddr1), .io_IDU_raddr2(io_IDU_raddr2),
      .io_IDU_waddr(io_IDU_waddr), .io_IDU_wen(io_IDU_wen), .io_IDU_fire(io_IDU_fire),
      .io_IDU_busy1(io_IDU_busy1), .io_IDU_busy2(io_IDU_busy2), .io_IDU_full(io_IDU_full),
      .io_WBU_waddr(io_WBU_waddr), .io_WBU_wen(io_WBU_wen), .io_flush(io_flush), .io_err(io_err)
   );

   always #5 clock = ~clock;

   int cntModel [NREG];
   bit errModel;
   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string tag, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic bit wbWrites(input int r);
      for (int k = 0; k < NWB; k++)
         if (io_WBU_wen[k] && int'(io_WBU_waddr[k*AW +: AW]) == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit modelBusy(input int r);
      if (!io_IDU_valid || r == 0 || r >= NREG || cntModel[r] == 0) return 1'b0;
`ifdef SCORE_BOARD_BYPASS_EN
      if (cntModel[r] == 1 && wbWrites(r)) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic bit modelFull();
      int w = int'(io_IDU_waddr);
      return io_IDU_valid && io_IDU_wen && w != 0 && w < NREG && cntModel[w] == MAXC;
   endfunction

   task automatic applyStimulus(input bit v, input int r1, input int r2, input int wa,
                                input bit wen, input bit fire, input int a0, input bit e0,
                                input int a1, input bit e1, input bit fl);
      io_IDU_valid  = v;
      io_IDU_raddr1 = AW'(r1);
      io_IDU_raddr2 = AW'(r2);
      io_IDU_waddr  = AW'(wa);
      io_IDU_wen    = wen;
      io_IDU_fire   = fire;
      io_WBU_waddr  = {AW'(a1), AW'(a0)};
      io_WBU_wen    = {e1, e0};
      io_flush      = fl;
   endtask

   // Compare against the model mid-cycle, then advance the model with the applied inputs.
   task automatic runCycle();
      int n;
      @(negedge clock);
      checkOutput("busy1", io_IDU_busy1, modelBusy(int'(io_IDU_raddr1)));
      checkOutput("busy2", io_IDU_busy2, modelBusy(int'(io_IDU_raddr2)));
      checkOutput("full",  io_IDU_full,  modelFull());
      checkOutput("err",   io_err,       errModel);
      @(posedge clock);
      if (reset) begin
         foreach (cntModel[i]) cntModel[i] = 0;
         errModel = 1'b0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            n = cntModel[i];
            if (io_IDU_fire && io_IDU_wen && int'(io_IDU_waddr) == i) n++;
            for (int k = 0; k < NWB; k++)
               if (io_WBU_wen[k] && int'(io_WBU_waddr[k*AW +: AW]) == i) n--;
            if (n < 0)    begin n = 0;    errModel = 1'b1; end
            if (n > MAXC) begin n = MAXC; errModel = 1'b1; end
            cntModel[i] = io_flush ? 0 : n;
         end
      end
      #1;
   endtask

   initial begin
      foreach (cntModel[i]) cntModel[i] = 0;
      errModel = 1'b0;
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      runCycle();
      runCycle();
      reset = 1'b0;

      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 5, 0, 5, 1, 1, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_busy5", io_IDU_busy1, 1'b1);
      runCycle();
      applyStimulus(1, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0); runCycle();
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_free5", io_IDU_busy1, 1'b0);
      runCycle();

      repeat (3) begin applyStimulus(1, 7, 0, 7, 1, 1, 0, 0, 0, 0, 0); runCycle(); end
      applyStimulus(1, 7, 0, 7, 1, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_full7", io_IDU_full, 1'b1);
      runCycle();
      applyStimulus(1, 7, 0, 7, 1, 0, 7, 1, 7, 1, 0); runCycle();
      applyStimulus(1, 7, 0, 7, 1, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_notfull7", io_IDU_full, 1'b0);
      runCycle();
      applyStimulus(1, 7, 0, 0, 0, 0, 7, 1, 0, 0, 0); runCycle();
      applyStimulus(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();

      applyStimulus(1, 9, 0, 9, 1, 1, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 9, 0, 9, 1, 1, 9, 1, 0, 0, 0); runCycle();
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_busy9", io_IDU_busy1, 1'b1);
      runCycle();

      applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0); runCycle();
      applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_err", io_err, 1'b1);
      runCycle();

      applyStimulus(1, 2, 6, 2, 1, 1, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 2, 6, 6, 1, 1, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 2, 6, 31, 1, 1, 0, 0, 0, 0, 0); runCycle();
      applyStimulus(1, 2, 31, 2, 1, 1, 0, 0, 0, 0, 1); runCycle();
      applyStimulus(1, 2, 31, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_flush", io_IDU_busy1 | io_IDU_busy2, 1'b0);
      runCycle();
      reset = 1'b1; runCycle(); reset = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("tp_rst_err", io_err, 1'b0);
      runCycle();

      // Random traffic concentrated on a few registers so counters saturate and drain often.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         applyStimulus($urandom_range(0, 3) != 0,
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 59) == 0);
         if ($urandom_range(0, 30) == 0) io_IDU_waddr = AW'($urandom_range(0, NREG - 1));
         runCycle();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
